// File: rtl/sincos_cordic_if.sv
// Handshake and data bundle for the sin/cos CORDIC.
//   master: requester side, drives start/angle and observes the result.
//   slave : the CORDIC itself.
// Signals:
//   start   - request, sampled only while busy=0
//   angle   - signed Q8.24 degrees
//   busy    - computation in progress
//   done    - one-cycle pulse when cos_out/sin_out are updated
//   cos_out - signed Q2.30 cosine
//   sin_out - signed Q2.30 sine
interface sincos_cordic_if;
    logic        start;
    logic [31:0] angle;
    logic        busy;
    logic        done;
    logic [31:0] cos_out;
    logic [31:0] sin_out;

    modport master (output start, angle, input busy, done, cos_out, sin_out);
    modport slave  (input start, angle, output busy, done, cos_out, sin_out);
endinterface

// File: rtl/sincos_cordic.sv
// Iterative rotation-mode CORDIC: angle in degrees (Q8.24) -> cos/sin (Q2.30).
// One micro-rotation per clock; the angle is folded into [-90,+90] first and
// the result negated when a fold took place.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - sincos_cordic_if.slave (start/angle in, busy/done/cos_out/sin_out out)
// Parameter:
//   ITER  - number of micro-rotations, 8..38
module sincos_cordic #(
    parameter int unsigned ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    sincos_cordic_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ROT  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // CORDIC gain compensation, round(0.6072529350 * 2^38)
    localparam logic signed [39:0] K      = 40'sd166920415758;
    // 180.0 degrees in Q8.32 exceeds the signed range; the fold arithmetic
    // is modulo 2^40 so the wrapped constant still gives the right result
    localparam logic [39:0]        DEG180 = 40'hB4_0000_0000;
    localparam logic signed [31:0] DEG90  = 32'sh5A00_0000;
    localparam logic signed [31:0] DEGM90 = -32'sh5A00_0000;
    localparam logic [5:0]         LAST   = 6'(ITER - 1);

    // atan(2^-idx) in degrees, Q8.32
    function automatic logic [39:0] atan_lut(input logic [5:0] idx);
        case (idx)
            6'd0:  atan_lut = 40'd193273528320;
            6'd1:  atan_lut = 40'd114096026022;
            6'd2:  atan_lut = 40'd60285206653;
            6'd3:  atan_lut = 40'd30601712202;
            6'd4:  atan_lut = 40'd15360239180;
            6'd5:  atan_lut = 40'd7687607525;
            6'd6:  atan_lut = 40'd3844741810;
            6'd7:  atan_lut = 40'd1922488225;
            6'd8:  atan_lut = 40'd961258780;
            6'd9:  atan_lut = 40'd480631223;
            6'd10: atan_lut = 40'd240315841;
            6'd11: atan_lut = 40'd120157949;
            6'd12: atan_lut = 40'd60078978;
            6'd13: atan_lut = 40'd30039490;
            6'd14: atan_lut = 40'd15019745;
            6'd15: atan_lut = 40'd7509872;
            6'd16: atan_lut = 40'd3754936;
            6'd17: atan_lut = 40'd1877468;
            6'd18: atan_lut = 40'd938734;
            6'd19: atan_lut = 40'd469367;
            6'd20: atan_lut = 40'd234684;
            6'd21: atan_lut = 40'd117342;
            6'd22: atan_lut = 40'd58671;
            6'd23: atan_lut = 40'd29335;
            6'd24: atan_lut = 40'd14668;
            6'd25: atan_lut = 40'd7334;
            6'd26: atan_lut = 40'd3667;
            6'd27: atan_lut = 40'd1833;
            6'd28: atan_lut = 40'd917;
            6'd29: atan_lut = 40'd458;
            6'd30: atan_lut = 40'd229;
            6'd31: atan_lut = 40'd115;
            6'd32: atan_lut = 40'd57;
            6'd33: atan_lut = 40'd29;
            6'd34: atan_lut = 40'd14;
            6'd35: atan_lut = 40'd7;
            6'd36: atan_lut = 40'd4;
            6'd37: atan_lut = 40'd2;
            default: atan_lut = '0;
        endcase
    endfunction

    logic [1:0]         state;
    logic signed [39:0] x, y, z;
    logic               neg;
    logic [5:0]         i;
    logic [31:0]        ang_q;
    logic               busy_q, done_q;
    logic [31:0]        cos_q, sin_q;

    logic [39:0]        ang_ext;
    logic signed [39:0] xs, ys, at;

    always_comb begin
        ang_ext = {ang_q, 8'b0};
        xs      = x >>> i;
        ys      = y >>> i;
        at      = $signed(atan_lut(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            x      <= '0;
            y      <= '0;
            z      <= '0;
            neg    <= 1'b0;
            i      <= '0;
            ang_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cos_q  <= '0;
            sin_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        ang_q  <= bus.angle;
                        busy_q <= 1'b1;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // fold into [-90,+90]; exactly +/-90 stays unfolded
                    if ($signed(ang_q) > DEG90) begin
                        z   <= ang_ext - DEG180;
                        neg <= 1'b1;
                    end else if ($signed(ang_q) < DEGM90) begin
                        z   <= ang_ext + DEG180;
                        neg <= 1'b1;
                    end else begin
                        z   <= ang_ext;
                        neg <= 1'b0;
                    end
                    x     <= K;
                    y     <= '0;
                    i     <= '0;
                    state <= S_ROT;
                end
                S_ROT: begin
                    if (!z[39]) begin
                        x <= x - ys;
                        y <= y + xs;
                        z <= z - at;
                    end else begin
                        x <= x + ys;
                        y <= y - xs;
                        z <= z + at;
                    end
                    if (i == LAST) state <= S_DONE;
                    else           i     <= i + 6'd1;
                end
                S_DONE: begin
                    cos_q  <= neg ? -x[39:8] : x[39:8];
                    sin_q  <= neg ? -y[39:8] : y[39:8];
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.cos_out = cos_q;
    assign bus.sin_out = sin_q;

endmodule
